sc_rr_crossbar_arbiter: RTL

Round-robin arbiter that grants one of NUM_MASTERS requesters access to a shared slave bus in the crossbar. It produces the one-hot per-master enable that drives each master's tristate bus buffer, holds the grant until the slave acknowledges, and inserts one all-disabled turnaround cycle between grants so no two buffers ever drive the bus together. One instance sits in front of each slave port.

---
 rtl/sc_rr_crossbar_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sc_rr_crossbar_arbiter.sv
// Round-robin arbiter for one slave port: one-hot tristate enables, grant held to ack,
// one all-disabled turnaround cycle between grants. Optional watchdog: SC_RR_ARB_TIMEOUT_EN.
module sc_rr_crossbar_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int ID_W          = $clog2(NUM_MASTERS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic                   i_ack,
  output logic [NUM_MASTERS-1:0] o_enable,
  output logic [ID_W-1:0]        o_grant_id,
  output logic                   o_busy,
  output logic                   o_timeout
);

  // state | meaning
  // IDLE  | no grant; pick the next requester scanning from ptr
  // BUSY  | one master enabled, waiting for ack, abandon or watchdog
  // TURN  | single all-disabled cycle so two buffers never overlap
  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        ptr, ptr_nxt;
  logic [NUM_MASTERS-1:0] enable_nxt;
  logic [ID_W-1:0]        grant_id_nxt;
  logic                   busy_nxt;
  logic                   timeout_nxt;
  logic                   pick_valid;
  logic [ID_W-1:0]        pick_id;
  logic [ID_W:0]          scan;
  logic [ID_W:0]          grant_inc;
  logic [ID_W-1:0]        ptr_after;
  logic                   expire;
  logic                   release_now;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535)
  begin : g_illegal_params
    logic illegal_parameter_value;
  end

  // Descending scan so the smallest offset from ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    scan       = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      scan = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(NUM_MASTERS)) scan = scan - (ID_W+1)'(NUM_MASTERS);
      if (i_req[scan[ID_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = scan[ID_W-1:0];
      end
    end
  end

  assign grant_inc = {1'b0, o_grant_id} + (ID_W+1)'(1);
  assign ptr_after = (grant_inc == (ID_W+1)'(NUM_MASTERS)) ? '0 : grant_inc[ID_W-1:0];

`ifdef SC_RR_ARB_TIMEOUT_EN
  logic [15:0] wdog;

  assign expire = (state == BUSY) && (wdog == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || state != BUSY) wdog <= '0;
    else                        wdog <= wdog + 16'd1;
  end
`else
  assign expire = 1'b0;
`endif

  assign release_now = i_ack || !i_req[o_grant_id] || expire;

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    enable_nxt   = o_enable;
    grant_id_nxt = o_grant_id;
    busy_nxt     = o_busy;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt    = BUSY;
          enable_nxt   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_id;
          grant_id_nxt = pick_id;
          busy_nxt     = 1'b1;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_nxt   = TURN;
          ptr_nxt     = ptr_after;
          enable_nxt  = '0;
          busy_nxt    = 1'b0;
          // Ack or abandon in the expiry cycle is a normal completion.
          timeout_nxt = expire && !i_ack && i_req[o_grant_id];
        end
      end
      TURN: begin
        state_nxt  = IDLE;
        enable_nxt = '0;
        busy_nxt   = 1'b0;
      end
      default: begin
        state_nxt  = IDLE;
        enable_nxt = '0;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      ptr        <= '0;
      o_enable   <= '0;
      o_grant_id <= '0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      o_enable   <= enable_nxt;
      o_grant_id <= grant_id_nxt;
      o_busy     <= busy_nxt;
      o_timeout  <= timeout_nxt;
    end
  end

endmodule
